// File: rtl/aes_round_seq_q.sv
// aes_round_seq_q
// Round sequencer and input queue for an iterative AES round datapath.
// Accepted plaintext blocks are held in a FIFO while the core is busy. Each
// block goes through START (initial AddRoundKey load), NR rounds of
// ROUND_CYCLES clocks each, and DONE (result valid).
//
// Parameters:
//   KEY_BITS     128/192/256, gives NR = 10/12/14
//   ROUND_CYCLES clocks per round, 1..8
//   FIFO_DEPTH   queue depth in blocks, power of 2, >= 2
//
// Ports:
//   clk                       rising-edge clock
//   kill_n                    synchronous active-low reset
//   in_data / in_en           plaintext block and one-cycle push strobe
//   dp_start / dp_data        datapath load strobe and the block to load
//   dp_en_mixcol              MixColumns enable for the current round
//   key_ready / round_idx     round-key request strobe and key index
//   out_en                    datapath result valid (one cycle)
//   busy                      high from dp_start through out_en
//   fifo_level                number of queued blocks
//   in_en_collision_irq_pulse one-cycle pulse when a push was dropped
//
// Optional feature, macro AES_ROUND_SEQ_DECRYPT_EN:
//   adds input decrypt (queued with each block) and output dp_decrypt;
//   decrypt blocks walk round_idx downwards from NR to 0.
module aes_round_seq_q #(
  parameter int KEY_BITS     = 128,
  parameter int ROUND_CYCLES = 3,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          kill_n,
  input  logic [127:0]                  in_data,
  input  logic                          in_en,
`ifdef AES_ROUND_SEQ_DECRYPT_EN
  input  logic                          decrypt,
  output logic                          dp_decrypt,
`endif
  output logic                          dp_start,
  output logic [127:0]                  dp_data,
  output logic                          dp_en_mixcol,
  output logic                          key_ready,
  output logic [3:0]                    round_idx,
  output logic                          out_en,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          in_en_collision_irq_pulse
);

  localparam int NR = (KEY_BITS == 256) ? 14 : (KEY_BITS == 192) ? 12 : 10;
  localparam logic [3:0] NR_L = 4'(NR);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = 3;
  localparam logic [CW-1:0] C_LAST = CW'(ROUND_CYCLES - 1);
`ifdef AES_ROUND_SEQ_DECRYPT_EN
  localparam int EW = 129;
`else
  localparam int EW = 128;
`endif

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] ROUND = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [EW-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [LW-1:0]  level_reg;
  logic [1:0]     state_reg, state_next;
  logic [3:0]     r_reg, r_next;
  logic [CW-1:0]  c_reg, c_next;
  logic [EW-1:0]  in_entry, head_entry;
  logic           push, pop, dec_sel;
  logic [3:0]     round_idx_next;

`ifdef AES_ROUND_SEQ_DECRYPT_EN
  assign in_entry = {decrypt, in_data};
`else
  assign in_entry = in_data;
`endif

  // The head is popped at the end of the START cycle; a full FIFO can take a
  // push in that same cycle because the slot frees up on the same edge.
  assign pop  = (state_reg == START);
  assign push = in_en && ((level_reg != LW'(FIFO_DEPTH)) || pop);

  // When the queue is empty, the block being pushed this cycle is the head
  // that START will load, so bypass the memory.
  assign head_entry = (level_reg == '0) ? in_entry : mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= in_entry;
  end

  always_comb begin
    state_next = state_reg;
    r_next     = r_reg;
    c_next     = c_reg;
    case (state_reg)
      IDLE: begin
        if ((level_reg != '0) || push) state_next = START;
      end
      START: begin
        state_next = ROUND;
        r_next     = 4'd1;
        c_next     = '0;
      end
      ROUND: begin
        if (c_reg == C_LAST) begin
          if (r_reg < NR_L) begin
            r_next = r_reg + 4'd1;
            c_next = '0;
          end else begin
            state_next = DONE;
          end
        end else begin
          c_next = c_reg + CW'(1);
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Direction of the block occupying the next cycle: taken from the head on
  // entry to START, then held in the registered output.
`ifdef AES_ROUND_SEQ_DECRYPT_EN
  assign dec_sel = (state_next == START) ? head_entry[128] : dp_decrypt;
`else
  assign dec_sel = 1'b0;
`endif

  always_comb begin
    round_idx_next = 4'd0;
    case (state_next)
      START:   round_idx_next = dec_sel ? NR_L : 4'd0;
      ROUND:   round_idx_next = dec_sel ? (NR_L - r_next) : r_next;
      DONE:    round_idx_next = dec_sel ? 4'd0 : NR_L;
      default: round_idx_next = 4'd0;
    endcase
  end

  // All outputs are registered from next-state values so they line up with
  // the state they describe.
  always_ff @(posedge clk) begin
    if (!kill_n) begin
      state_reg                 <= IDLE;
      r_reg                     <= '0;
      c_reg                     <= '0;
      wr_ptr_reg                <= '0;
      rd_ptr_reg                <= '0;
      level_reg                 <= '0;
      dp_start                  <= 1'b0;
      dp_data                   <= '0;
      dp_en_mixcol              <= 1'b0;
      key_ready                 <= 1'b0;
      round_idx                 <= '0;
      out_en                    <= 1'b0;
      busy                      <= 1'b0;
      in_en_collision_irq_pulse <= 1'b0;
`ifdef AES_ROUND_SEQ_DECRYPT_EN
      dp_decrypt                <= 1'b0;
`endif
    end else begin
      state_reg  <= state_next;
      r_reg      <= r_next;
      c_reg      <= c_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      level_reg  <= level_reg + LW'(push) - LW'(pop);
      in_en_collision_irq_pulse <= in_en && !push;
      dp_start     <= (state_next == START);
      if (state_next == START) dp_data <= head_entry[127:0];
      key_ready    <= (state_next == START) ||
                      ((state_next == ROUND) && (c_next == '0));
      dp_en_mixcol <= (state_next == ROUND) && (r_next != NR_L);
      round_idx    <= round_idx_next;
      out_en       <= (state_next == DONE);
      busy         <= (state_next != IDLE);
`ifdef AES_ROUND_SEQ_DECRYPT_EN
      dp_decrypt   <= (state_next != IDLE) && dec_sel;
`endif
    end
  end

  assign fifo_level = level_reg;

endmodule

// File: doc/aes_round_seq_q.md
Name: aes_round_seq_q

Overview:
Parametrised round sequencer and input queue for the iterative AES round datapath. It is the successor to the fixed 128-bit, 10-round, 3-cycle controller, and supports 128/192/256-bit keys and a configurable number of cycles per round. Accepted blocks are buffered in a FIFO instead of being dropped while the core is busy. It drives the external round datapath (start/data/en_mixcol) and the key-schedule request strobe, and flags overflow with an interrupt pulse.

Parameters:
KEY_BITS, 128, key length; legal values 128/192/256; sets NR = 10/12/14.
ROUND_CYCLES, 3, clock cycles per round; legal range 1..8.
FIFO_DEPTH, 4, input queue depth in blocks; power of 2, at least 2.

Ports:
clk  in  1  clock; all logic is on the rising edge.
kill_n  in  1  synchronous active-low reset.
in_data  in  128  plaintext block.
in_en  in  1  one-cycle push strobe for in_data.
dp_start  out  1  one-cycle load strobe to the datapath (initial AddRoundKey).
dp_data  out  128  queue head; valid when dp_start=1.
dp_en_mixcol  out  1  MixColumns enable for the current round.
key_ready  out  1  one-cycle round-key request, paired with round_idx.
round_idx  out  4  index of the round key requested or in use.
out_en  out  1  one-cycle pulse; datapath result is valid.
busy  out  1  high from dp_start through out_en.
fifo_level  out  $clog2(FIFO_DEPTH)+1  number of queued blocks.
in_en_collision_irq_pulse  out  1  one-cycle pulse on a dropped push.

Behaviour:
- Reset (kill_n=0 at a clock edge): FIFO is emptied and the FSM goes to IDLE. On the next cycle every output is 0: dp_data=0, round_idx=0, fifo_level=0.
- Reset mid-operation aborts the block in flight. No out_en follows and the queue contents are lost.
- FIFO push: in_en=1 with fifo_level<FIFO_DEPTH writes in_data; fifo_level increments the next cycle.
- Full FIFO: in_en=1 with fifo_level=FIFO_DEPTH and no pop in the same cycle drops the block. in_en_collision_irq_pulse=1 on the following cycle.
- Full FIFO with a simultaneous pop: the push is accepted and fifo_level stays at FIFO_DEPTH.
- Push and pop in the same cycle at any level: fifo_level is unchanged. Pushes land behind the current head, so FIFO order is preserved.
- FSM states are IDLE, START, ROUND, DONE.
- IDLE: if fifo_level>0, go to START. A push into an empty FIFO at cycle t gives START at cycle t+1.
- START (1 cycle): pop the head; dp_start=1, dp_data=head, key_ready=1, round_idx=0, busy=1. Go to ROUND with r=1 and cycle counter c=0.
- ROUND: round r spans ROUND_CYCLES cycles.
  - key_ready=1 only when c=0; round_idx=r throughout the round.
  - dp_en_mixcol=1 for r in 1..NR-1 and 0 for r=NR, held for every cycle of the round.
  - When c=ROUND_CYCLES-1: if r<NR, set r=r+1 and c=0; else go to DONE.
- DONE (1 cycle): out_en=1, busy=1, round_idx=NR. Next state is IDLE. A queued block therefore reaches START two cycles after out_en.
- Latency from the dp_start cycle to the out_en cycle is NR*ROUND_CYCLES+1. Throughput is one block per NR*ROUND_CYCLES+3 cycles under back-to-back load.
- dp_start and out_en are never asserted in the same cycle.
- key_ready pulses exactly NR+1 times per block.
- All outputs are registered.
- round_idx width: 4 bits covers NR=14.

Optional Feature:
Macro AES_ROUND_SEQ_DECRYPT_EN.
- Defined:
  - Adds input port decrypt (1 bit), sampled with in_en and stored in the FIFO alongside in_data (the FIFO is 129 bits wide).
  - Adds output dp_decrypt, valid from START through DONE.
  - For decrypt blocks, round_idx counts down: NR at START, then NR-r during round r, ending at 0 in DONE.
  - The dp_en_mixcol pattern is unchanged and selects inverse MixColumns in the datapath.
- Undefined: ports decrypt and dp_decrypt do not exist; the block is encrypt-only and round_idx counts up.

Test Plan:
- Single block, defaults: in_en at cycle 0 -> dp_start at cycle 1; key_ready at cycles 1, 2, 5, 8, ..., 29 (11 pulses); dp_en_mixcol=0 during cycles 29-31; out_en at cycle 32.
- KEY_BITS=256, ROUND_CYCLES=2: in_en at cycle 0 -> dp_start at cycle 1; out_en at cycle 30; round_idx reaches 14; 15 key_ready pulses.
- Overflow, FIFO_DEPTH=4: in_en on cycles 0-5 -> cycle 5 push dropped; irq at cycle 6 only; fifo_level peaks at 4; 5 out_en total, with data in push order.
- Full FIFO plus pop: hold the FIFO full and push in the START (pop) cycle -> accepted, no irq, fifo_level remains 4.
- Reset mid-block: kill_n=0 at cycle 15 of a running block -> all outputs 0 from cycle 16; no out_en; fifo_level=0; a subsequent push runs normally.
- Decrypt (macro defined), KEY_BITS=128: decrypt=1 -> round_idx sequence 10, 9, ..., 0; out_en at cycle 32; dp_decrypt=1 from START through DONE.
